// File: rtl/sar_conv_ctrl_pkg.sv
// Shared types and default sizing for the SAR conversion sequencer.
// Imported by the top level so that state names and defaults have a single source.
package sar_conv_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SAMPLE   = 2'd1,
      WAIT_CMP = 2'd2,
      DONE     = 2'd3
   } sar_state_t;

   localparam int SAR_NBITS          = 8;
   localparam int SAR_SAMPLE_CYCLES  = 2;
   localparam int SAR_TIMEOUT_CYCLES = 16;

   // Counter widths sized for the upper end of the legal parameter ranges.
   localparam int SAR_SAMPLE_CNT_W   = 4;
   localparam int SAR_TIMEOUT_CNT_W  = 8;

endpackage

// File: rtl/sar_timeout_timer.sv
// Per-bit watchdog: counts enabled cycles and strobes expire on the LIMIT-th one.
// The count restarts on clear or on its own expiry, so back-to-back timeouts work.
module sar_timeout_timer #(
   parameter int LIMIT = 16,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expire
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expire = count_en && (cnt_q == CNT_LAST);

   // NOTE: cnt_d gets its default before any branch so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clear || expire) begin
         cnt_d = '0;
      end else if (count_en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: state flops use non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sar_conv_ctrl.sv
// SAR ADC conversion sequencer: sample window, then one bit resolved per comparator
// decision (or per-bit timeout), MSB first, with all outputs driven from flops.
module sar_conv_ctrl
   import sar_conv_ctrl_pkg::*;
#(
   parameter int NBITS          = SAR_NBITS,
   parameter int SAMPLE_CYCLES  = SAR_SAMPLE_CYCLES,
   parameter int TIMEOUT_CYCLES = SAR_TIMEOUT_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             comp_ready,
   input  logic             comp_out,
   output logic             sample_en,
   output logic             register_clk,
   output logic [NBITS-1:0] dac_code,
   output logic             busy,
   output logic [NBITS-1:0] data_out,
   output logic             data_valid,
   output logic             overrun,
   output logic             timeout_err
);

   localparam int IDX_W = $clog2(NBITS);
   localparam logic [SAR_SAMPLE_CNT_W-1:0] SAMPLE_LAST = SAR_SAMPLE_CNT_W'(SAMPLE_CYCLES - 1);
   localparam logic [IDX_W-1:0]            IDX_MSB     = IDX_W'(NBITS - 1);
   localparam logic [NBITS-1:0]            MSB_TRIAL   = NBITS'(1) << (NBITS - 1);

   sar_state_t                  state_q, state_d;
   logic [SAR_SAMPLE_CNT_W-1:0] samp_cnt_q, samp_cnt_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [NBITS-1:0]            dac_code_q, dac_code_d;
   logic [NBITS-1:0]            data_out_q, data_out_d;
   logic                        sample_en_q, sample_en_d;
   logic                        register_clk_q, register_clk_d;
   logic                        busy_q, busy_d;
   logic                        data_valid_q, data_valid_d;
   logic                        overrun_q, overrun_d;
   logic                        timeout_err_q, timeout_err_d;

   logic                        in_wait;
   logic                        tmr_expire;
   logic                        decided;
   logic                        timed_out;
   logic                        begin_conv;
   logic [NBITS-1:0]            resolved;

   assign in_wait    = (state_q == WAIT_CMP);
   assign decided    = in_wait && comp_ready;
   // A real decision in the expiry cycle takes precedence over the timeout.
   assign timed_out  = in_wait && !comp_ready && tmr_expire;
   assign begin_conv = start && ((state_q == IDLE) || (state_q == DONE));

   sar_timeout_timer #(
      .LIMIT (TIMEOUT_CYCLES),
      .CNT_W (SAR_TIMEOUT_CNT_W)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clear    (!in_wait || comp_ready),
      .count_en (in_wait),
      .expire   (tmr_expire)
   );

   always_comb begin
      state_d       = state_q;
      samp_cnt_d    = samp_cnt_q;
      idx_d         = idx_q;
      dac_code_d    = dac_code_q;
      data_out_d    = data_out_q;
      timeout_err_d = timeout_err_q;
      overrun_d     = 1'b0;
      resolved      = dac_code_q;

      case (state_q)
         IDLE: begin
         end

         SAMPLE: begin
            overrun_d = start;
            if (samp_cnt_q == SAMPLE_LAST) begin
               state_d    = WAIT_CMP;
               idx_d      = IDX_MSB;
               dac_code_d = MSB_TRIAL;
            end else begin
               samp_cnt_d = samp_cnt_q + 1'b1;
            end
         end

         WAIT_CMP: begin
            overrun_d = start;
            if (decided || timed_out) begin
               // The trial bit survives only on a real decision with Vin >= Vdac.
               if (!(decided && comp_out)) begin
                  resolved[idx_q] = 1'b0;
               end
               if (timed_out) begin
                  timeout_err_d = 1'b1;
               end
               if (idx_q == '0) begin
                  state_d    = DONE;
                  data_out_d = resolved;
                  dac_code_d = resolved;
               end else begin
                  idx_d                    = idx_q - 1'b1;
                  resolved[idx_q - 1'b1]   = 1'b1;
                  dac_code_d               = resolved;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Entry into SAMPLE from IDLE or back-to-back from DONE.
      if (begin_conv) begin
         state_d       = SAMPLE;
         samp_cnt_d    = '0;
         dac_code_d    = '0;
         timeout_err_d = 1'b0;
      end

      sample_en_d    = (state_d == SAMPLE);
      register_clk_d = (state_d == WAIT_CMP);
      busy_d         = (state_d != IDLE);
      data_valid_d   = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         samp_cnt_q     <= '0;
         idx_q          <= '0;
         dac_code_q     <= '0;
         data_out_q     <= '0;
         sample_en_q    <= 1'b0;
         register_clk_q <= 1'b0;
         busy_q         <= 1'b0;
         data_valid_q   <= 1'b0;
         overrun_q      <= 1'b0;
         timeout_err_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         samp_cnt_q     <= samp_cnt_d;
         idx_q          <= idx_d;
         dac_code_q     <= dac_code_d;
         data_out_q     <= data_out_d;
         sample_en_q    <= sample_en_d;
         register_clk_q <= register_clk_d;
         busy_q         <= busy_d;
         data_valid_q   <= data_valid_d;
         overrun_q      <= overrun_d;
         timeout_err_q  <= timeout_err_d;
      end
   end

   assign sample_en    = sample_en_q;
   assign register_clk = register_clk_q;
   assign dac_code     = dac_code_q;
   assign busy         = busy_q;
   assign data_out     = data_out_q;
   assign data_valid   = data_valid_q;
   assign overrun      = overrun_q;
   assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Scoreboard bench for sar_conv_ctrl: a comparator responder plus a binary-search
// reference model feeding expected results and trial codes into queues.
module tb_sar_conv_ctrl;

   localparam int NB = 8;
   localparam int S  = 2;
   localparam int T  = 16;

   typedef struct {
      logic [NB-1:0] data;
      logic          terr;
      int            start_cyc;
      int            lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          comp_ready = 1'b0;
   logic          comp_out = 1'b0;
   logic          sample_en;
   logic          register_clk;
   logic [NB-1:0] dac_code;
   logic          busy;
   logic [NB-1:0] data_out;
   logic          data_valid;
   logic          overrun;
   logic          timeout_err;

   int            vectors = 0;
   int            miscompares = 0;
   int            cyc = 0;
   int            samp_seen = 0;
   int            rclk_seen = 0;
   int            ovr_seen = 0;
   int            ovr_exp = 0;

   logic [NB-1:0] vin = '0;
   int            cmp_delay = 0;
   bit            noise_en = 1'b0;

   exp_t          exp_q[$];
   logic [NB-1:0] trial_q[$];

   sar_conv_ctrl #(
      .NBITS          (NB),
      .SAMPLE_CYCLES  (S),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .comp_ready   (comp_ready),
      .comp_out     (comp_out),
      .sample_en    (sample_en),
      .register_clk (register_clk),
      .dac_code     (dac_code),
      .busy         (busy),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .overrun      (overrun),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Ideal comparator; cmp_delay < 0 means it never answers.
   bit first_cmp = 1'b1;
   int cmp_cnt = 0;
   logic [NB-1:0] last_code = '0;
   always @(negedge clk) begin
      if (!register_clk) begin
         first_cmp  = 1'b1;
         comp_ready = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
         comp_out   = 1'($urandom_range(0, 1));
      end else begin
         if (first_cmp || dac_code != last_code) begin
            cmp_cnt = 0;
            if (trial_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL dac_trial: got %0h, expected no trial", dac_code);
            end else begin
               check("dac_trial", 32'(dac_code), 32'(trial_q.pop_front()));
            end
         end
         first_cmp = 1'b0;
         last_code = dac_code;
         if (cmp_delay >= 0 && cmp_cnt == cmp_delay) begin
            comp_ready = 1'b1;
            comp_out   = (vin >= dac_code);
         end else begin
            comp_ready = 1'b0;
            comp_out   = 1'($urandom_range(0, 1));
         end
         cmp_cnt++;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (sample_en)    samp_seen++;
         if (register_clk) rclk_seen++;
         if (overrun)      ovr_seen++;
         if (data_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL data_valid: got unexpected result %0h, expected none", data_out);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("data_out", 32'(data_out), 32'(e.data));
               check("timeout_err", 32'(timeout_err), 32'(e.terr));
               check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
               check("sample_cycles", 32'(samp_seen), 32'(S));
               check("wait_cycles", 32'(rclk_seen), 32'(e.lat - S));
               check("busy_done", 32'(busy), 32'd1);
            end
            samp_seen = 0;
            rclk_seen = 0;
         end
      end
   end

   // Must be called at a negedge; start is sampled on the following posedge (edge 0).
   task automatic issue(input logic [NB-1:0] v, input int d);
      exp_t          e;
      logic [NB-1:0] code;
      logic [NB-1:0] trial;
      vin       = v;
      cmp_delay = d;
      code      = '0;
      for (int b = NB - 1; b >= 0; b--) begin
         trial = code | (NB'(1) << b);
         trial_q.push_back(trial);
         if (d >= 0 && v >= trial) code = trial;
      end
      e.data      = code;
      e.terr      = (d < 0);
      e.start_cyc = cyc + 1;
      e.lat       = S + NB * ((d < 0) ? T : d + 1);
      exp_q.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (data_valid) break;
      end
      check("valid_seen", 32'(data_valid), 32'd1);
   endtask

   task automatic wait_idle(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) break;
      end
      check("idle_reached", 32'(exp_q.size()), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_sample_en", 32'(sample_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_dac_code", 32'(dac_code), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_outputs", 32'({register_clk, data_valid, overrun, timeout_err}), 32'd0);

      // Ideal comparator answering every cycle.
      issue(8'hA5, 0);
      wait_idle(200);

      // Slow comparator, both rails.
      issue(8'h00, 3);
      wait_idle(200);
      issue(8'hFF, 3);
      wait_idle(200);

      // Comparator never answers; then the next start clears the sticky flag.
      issue(8'hC3, -1);
      wait_idle(400);
      check("terr_sticky", 32'(timeout_err), 32'd1);
      issue(8'h81, 0);
      check("terr_cleared", 32'(timeout_err), 32'd0);
      wait_idle(200);

      // Decision arriving in the same cycle the timeout would expire.
      issue(8'h6D, T - 1);
      wait_idle(400);

      // start while SAMPLE and while WAIT_CMP.
      issue(8'h3C, 2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ovr_exp += 2;
      wait_idle(200);
      check("overrun_pulses", 32'(ovr_seen), 32'(ovr_exp));

      // Back-to-back: start in the DONE cycle.
      issue(8'h12, 0);
      wait_valid(200);
      issue(8'h34, 0);
      check("b2b_sample_en", 32'(sample_en), 32'd1);
      check("b2b_busy", 32'(busy), 32'd1);
      wait_idle(200);
      check("b2b_no_overrun", 32'(ovr_seen), 32'(ovr_exp));

      // Reset in the middle of bit 4.
      issue(8'h77, 0);
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_outputs", 32'({sample_en, register_clk, busy, data_valid, timeout_err}), 32'd0);
      check("midrst_data_out", 32'(data_out), 32'd0);
      check("midrst_dac_code", 32'(dac_code), 32'd0);
      exp_q.delete();
      trial_q.delete();
      samp_seen = 0;
      rclk_seen = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      issue(8'h5A, 0);
      wait_idle(200);

      // Randomized conversions, some back-to-back, with comparator noise outside WAIT_CMP.
      for (int n = 0; n < 20; n++) begin
         int r;
         int d;
         r = int'($urandom_range(0, 9));
         d = (r == 0) ? -1 : (r < 3) ? T - 1 : int'($urandom_range(0, 3));
         noise_en = 1'($urandom_range(0, 1));
         if (exp_q.size() != 0 && $urandom_range(0, 1) == 1) begin
            wait_valid(400);
         end else begin
            wait_idle(400);
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         issue(NB'($urandom), d);
      end
      wait_idle(400);
      check("final_overrun", 32'(ovr_seen), 32'(ovr_exp));
      check("final_trials_used", 32'(trial_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
